// File: rtl/router_output_buffer.sv
// Output-port FIFO fed by the crossbar on arbiter grants, drained by the outbound link
// through a valid/ready handshake. Status flags decode only from the registered count.
module router_output_buffer #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       out_ready,
    output logic                       err_ovf
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              err_ovf_q, err_ovf_d;
    logic              empty_s, full_s, push_s, pop_s;

    assign empty_s = (count_q == {CNT_W{1'b0}});
    assign full_s  = (count_q == CNT_W'(DEPTH));

    // Handshake decode and next-state computation for pointers, count and overflow flag.
    always_comb begin
        pop_s     = !empty_s && out_ready;
        push_s    = wr_en && (!full_s || pop_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        err_ovf_d = err_ovf_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // A write is lost only when full and the link is not draining this cycle.
        if (wr_en && !push_s) begin
            err_ovf_d = 1'b1;
        end else begin
            err_ovf_d = err_ovf_q;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= {ADDR_W{1'b0}};
            rd_ptr_q  <= {ADDR_W{1'b0}};
            count_q   <= {CNT_W{1'b0}};
            err_ovf_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_ovf_q <= err_ovf_d;
        end
    end

    // Storage array; contents are irrelevant after reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign empty     = empty_s;
    assign full      = full_s;
    assign count     = count_q;
    assign out_valid = !empty_s;
    assign out_data  = empty_s ? {DATA_W{1'b0}} : mem_q[rd_ptr_q];
    assign err_ovf   = err_ovf_q;

endmodule
